// File: rtl/discharge_pkg.sv
// Shared definitions for the discharge pulse parameter bank: FSM states, slot indices and
// the default parameter width.
package discharge_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopPend = 2'd2
    } state_e;

    localparam int unsigned IDX_TON  = 0;
    localparam int unsigned IDX_TOFF = 1;
    localparam int unsigned IDX_IP   = 2;
    localparam int unsigned IDX_WAVE = 3;

    localparam int unsigned DEFAULT_DATA_W = 16;

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer for one asynchronous level-held ack, followed by a rising-edge
// detector. SYNC_STAGES must be at least 2.
module ack_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ack_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   prev_q;

    // prev_q starts high and only tracks genuine post-reset samples, so an ack held high
    // through reset release never looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            valid_q <= '0;
            prev_q  <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_i};
            valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            if (valid_q[SYNC_STAGES-1]) begin
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pulse_param_bank.sv
// Double-buffered discharge parameter bank with machine start/stop FSM. Define
// PULSE_PARAM_CLAMP_EN to clamp captured values against param_max and flag clamp_err.
module pulse_param_bank
    import discharge_pkg::*;
#(
    parameter int unsigned                 NUM_PARAM    = 4,
    parameter int unsigned                 DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned                 SYNC_STAGES  = 2,
    parameter int unsigned                 STOP_TIMEOUT = 16'd10000,
    parameter logic [NUM_PARAM*DATA_W-1:0] PARAM_RESET  = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          machine_start_ack,
    input  logic                          machine_stop_ack,
    input  logic [NUM_PARAM-1:0]          change_ack,
    input  logic [NUM_PARAM*DATA_W-1:0]   param_data_async,
    input  logic [NUM_PARAM*DATA_W-1:0]   param_max,
    input  logic                          cycle_done,
    output logic                          is_machine,
    output logic [NUM_PARAM*DATA_W-1:0]   param_data,
    output logic [NUM_PARAM-1:0]          param_pending,
    output logic                          param_updated,
    output logic                          clamp_err
);

    localparam int unsigned CNT_W = (STOP_TIMEOUT > 2) ? $clog2(STOP_TIMEOUT) : 1;

    logic                 start_rise;
    logic                 stop_rise;
    logic [NUM_PARAM-1:0] change_rise;

    ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ack_i  (machine_start_ack),
        .rise_o (start_rise)
    );

    ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ack_i  (machine_stop_ack),
        .rise_o (stop_rise)
    );

    for (genvar g = 0; g < NUM_PARAM; g++) begin : g_change_sync
        ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_change_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .ack_i  (change_ack[g]),
            .rise_o (change_rise[g])
        );
    end

    // Value presented to the shadow registers on a capture.
    logic [NUM_PARAM*DATA_W-1:0] capt_val;

`ifdef PULSE_PARAM_CLAMP_EN
    logic [NUM_PARAM-1:0] over_max;
    logic                 clamp_err_q;
    logic                 clamp_err_d;

    always_comb begin
        capt_val = param_data_async;
        over_max = '0;
        for (int i = 0; i < NUM_PARAM; i++) begin
            if (param_data_async[i*DATA_W +: DATA_W] > param_max[i*DATA_W +: DATA_W]) begin
                over_max[i]                  = 1'b1;
                capt_val[i*DATA_W +: DATA_W] = param_max[i*DATA_W +: DATA_W];
            end
        end
        clamp_err_d = clamp_err_q | (|(over_max & change_rise));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clamp_err_q <= 1'b0;
        end else begin
            clamp_err_q <= clamp_err_d;
        end
    end

    assign clamp_err = clamp_err_q;
`else
    logic unused_param_max;

    assign unused_param_max = ^param_max;
    assign capt_val         = param_data_async;
    assign clamp_err        = 1'b0;
`endif

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        timeout;
    logic                        is_machine_q;
    logic [NUM_PARAM*DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_PARAM*DATA_W-1:0] data_q, data_d;
    logic [NUM_PARAM-1:0]        pending_q, pending_d;
    logic [NUM_PARAM-1:0]        commit;
    logic                        commit_en;
    logic                        updated_q, updated_d;

    assign timeout = (cnt_q == CNT_W'(STOP_TIMEOUT - 1));

    // Stop wins over a coincident start; start is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (start_rise && !stop_rise) state_d = StRun;
            StRun:      if (stop_rise) state_d = StStopPend;
            StStopPend: if (cycle_done || timeout) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        cnt_d = (state_q == StStopPend) ? cnt_q + CNT_W'(1) : '0;
    end

    // Commit reads shadow_q, so a same-edge capture stays pending for the next commit.
    always_comb begin
        commit_en = (state_q == StIdle) || cycle_done;
        commit    = pending_q & {NUM_PARAM{commit_en}};
        shadow_d  = shadow_q;
        data_d    = data_q;
        pending_d = pending_q;
        for (int i = 0; i < NUM_PARAM; i++) begin
            if (commit[i]) begin
                data_d[i*DATA_W +: DATA_W] = shadow_q[i*DATA_W +: DATA_W];
            end
            if (change_rise[i]) begin
                shadow_d[i*DATA_W +: DATA_W] = capt_val[i*DATA_W +: DATA_W];
            end
            pending_d[i] = change_rise[i] | (pending_q[i] & ~commit[i]);
        end
        updated_d = |commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            is_machine_q <= 1'b0;
            shadow_q     <= PARAM_RESET;
            data_q       <= PARAM_RESET;
            pending_q    <= '0;
            updated_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_machine_q <= (state_d != StIdle);
            shadow_q     <= shadow_d;
            data_q       <= data_d;
            pending_q    <= pending_d;
            updated_q    <= updated_d;
        end
    end

    assign is_machine    = is_machine_q;
    assign param_data    = data_q;
    assign param_pending = pending_q;
    assign param_updated = updated_q;

endmodule

// File: tb/tb_pulse_param_bank.sv
// Self-checking bench for pulse_param_bank: directed timing sequences, a vector table of
// IDLE writes, and randomized operations checked against a transaction-level model.
module tb_pulse_param_bank;
    import discharge_pkg::*;

    localparam int unsigned NP  = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 100;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            machine_start_ack;
    logic            machine_stop_ack;
    logic [NP-1:0]   change_ack;
    logic [NP*DW-1:0] param_data_async;
    logic [NP*DW-1:0] param_max;
    logic            cycle_done;
    logic            is_machine;
    logic [NP*DW-1:0] param_data;
    logic [NP-1:0]   param_pending;
    logic            param_updated;
    logic            clamp_err;

    pulse_param_bank #(
        .NUM_PARAM    (NP),
        .DATA_W       (DW),
        .SYNC_STAGES  (2),
        .STOP_TIMEOUT (TMO),
        .PARAM_RESET  ('0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .machine_start_ack (machine_start_ack),
        .machine_stop_ack  (machine_stop_ack),
        .change_ack        (change_ack),
        .param_data_async  (param_data_async),
        .param_max         (param_max),
        .cycle_done        (cycle_done),
        .is_machine        (is_machine),
        .param_data        (param_data),
        .param_pending     (param_pending),
        .param_updated     (param_updated),
        .clamp_err         (clamp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: state 0 idle, 1 run, 2 stop pending.
    logic [DW-1:0] m_data   [NP];
    logic [DW-1:0] m_shadow [NP];
    logic [NP-1:0] m_pend;
    int            m_state;
    logic          m_err;

    typedef struct {
        int        slot;
        logic [15:0] val;
        logic [15:0] exp;
        logic      exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_change(input int slot, input logic [15:0] val);
        param_data_async[slot*DW +: DW] = val;
        change_ack[slot] = 1'b1;
        repeat (5) tick();
        change_ack[slot] = 1'b0;
        repeat (5) tick();
    endtask

    task automatic pulse_ctl(input bit is_stop);
        if (is_stop) machine_stop_ack = 1'b1;
        else         machine_start_ack = 1'b1;
        repeat (5) tick();
        machine_stop_ack  = 1'b0;
        machine_start_ack = 1'b0;
        repeat (5) tick();
    endtask

    task automatic pulse_done();
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        repeat (2) tick();
    endtask

    function automatic logic [15:0] slot_of(input logic [63:0] v, input int slot);
        logic [63:0] t;
        t = v >> (slot * DW);
        return t[15:0];
    endfunction

    task automatic model_write(input int slot, input logic [15:0] val);
        logic [15:0] v;
        v = val;
`ifdef PULSE_PARAM_CLAMP_EN
        if (v > slot_of(param_max, slot)) begin
            v     = slot_of(param_max, slot);
            m_err = 1'b1;
        end
`endif
        if (m_state == 0) begin
            m_data[slot] = v;
        end else begin
            m_shadow[slot] = v;
            m_pend[slot]   = 1'b1;
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < NP; i++) begin
            if (m_pend[i]) m_data[i] = m_shadow[i];
        end
        m_pend = '0;
    endtask

    task automatic check_model(input string tag);
        logic [63:0] exp_data;
        for (int i = 0; i < NP; i++) exp_data[i*DW +: DW] = m_data[i];
        check({tag, " data"},       param_data, exp_data);
        check({tag, " pending"},    64'(param_pending), 64'(m_pend));
        check({tag, " is_machine"}, 64'(is_machine), 64'(m_state != 0));
        check({tag, " clamp_err"},  64'(clamp_err), 64'(m_err));
    endtask

    logic [15:0] rv;
    int          rslot;

    initial begin
        rst_n             = 1'b0;
        machine_start_ack = 1'b0;
        machine_stop_ack  = 1'b0;
        change_ack        = '0;
        param_data_async  = '0;
        cycle_done        = 1'b0;
        param_max         = {16'd1000, 16'd80, 16'hFFFF, 16'hFFFF};

        repeat (3) tick();
        check("reset is_machine", 64'(is_machine), 64'd0);
        check("reset data",       param_data, 64'd0);
        check("reset pending",    64'(param_pending), 64'd0);
        check("reset updated",    64'(param_updated), 64'd0);
        check("reset clamp_err",  64'(clamp_err), 64'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Capture latency and single-cycle update strobe in IDLE.
        param_data_async[0 +: DW] = 16'd200;
        change_ack[0] = 1'b1;
        tick();
        check("lat e1 pending", 64'(param_pending), 64'd0);
        tick();
        check("lat e2 pending", 64'(param_pending), 64'd0);
        tick();
        check("lat e3 pending", 64'(param_pending), 64'b0001);
        check("lat e3 data",    64'(slot_of(param_data, IDX_TON)), 64'd0);
        check("lat e3 updated", 64'(param_updated), 64'd0);
        tick();
        check("lat e4 data",    64'(slot_of(param_data, IDX_TON)), 64'd200);
        check("lat e4 pending", 64'(param_pending), 64'd0);
        check("lat e4 updated", 64'(param_updated), 64'd1);
        tick();
        check("lat e5 updated", 64'(param_updated), 64'd0);
        change_ack[0] = 1'b0;
        repeat (5) tick();

        // Coincident start and stop in IDLE: stop wins.
        machine_start_ack = 1'b1;
        machine_stop_ack  = 1'b1;
        repeat (5) tick();
        machine_start_ack = 1'b0;
        machine_stop_ack  = 1'b0;
        repeat (5) tick();
        check("start+stop stays idle", 64'(is_machine), 64'd0);

        // Writes in RUN are held until cycle_done, then commit together.
        pulse_ctl(1'b0);
        check("run is_machine", 64'(is_machine), 64'd1);
        pulse_change(IDX_TON, 16'd50);
        pulse_change(IDX_IP, 16'd30);
        check("run ton held", 64'(slot_of(param_data, IDX_TON)), 64'd200);
        check("run ip held",  64'(slot_of(param_data, IDX_IP)), 64'd0);
        check("run pending",  64'(param_pending), 64'b0101);
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        check("done ton",     64'(slot_of(param_data, IDX_TON)), 64'd50);
        check("done ip",      64'(slot_of(param_data, IDX_IP)), 64'd30);
        check("done pending", 64'(param_pending), 64'd0);
        check("done updated", 64'(param_updated), 64'd1);
        tick();
        check("done updated low", 64'(param_updated), 64'd0);
        check("done still run",   64'(is_machine), 64'd1);

        // Stop without cycle_done: state enters STOP_PEND on edge 3 and times out at 103.
        machine_stop_ack = 1'b1;
        for (int k = 1; k <= 103; k++) begin
            tick();
            if (k == 5) machine_stop_ack = 1'b0;
            if (k == 102) check("timeout before", 64'(is_machine), 64'd1);
            if (k == 103) check("timeout at 100", 64'(is_machine), 64'd0);
        end
        repeat (3) tick();

        // Asynchronous reset mid STOP_PEND with a pending slot.
        pulse_ctl(1'b0);
        pulse_ctl(1'b1);
        pulse_change(IDX_WAVE, 16'd9);
        check("stoppend pending", 64'(param_pending), 64'b1000);
        param_data_async[IDX_TOFF*DW +: DW] = 16'h1234;
        change_ack[IDX_TOFF] = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst is_machine", 64'(is_machine), 64'd0);
        check("async rst data",       param_data, 64'd0);
        check("async rst pending",    64'(param_pending), 64'd0);
        check("async rst updated",    64'(param_updated), 64'd0);
        check("async rst clamp_err",  64'(clamp_err), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("held ack no capture", 64'(param_pending), 64'd0);
        check("held ack no data",    param_data, 64'd0);
        change_ack[IDX_TOFF] = 1'b0;
        repeat (6) tick();

        for (int i = 0; i < NP; i++) begin
            m_data[i]   = '0;
            m_shadow[i] = '0;
        end
        m_pend  = '0;
        m_state = 0;
        m_err   = 1'b0;

        // Table of IDLE writes, including clamp boundaries.
        tbl[0] = '{IDX_TON,  16'd200,  16'd200,  1'b0};
        tbl[1] = '{IDX_TOFF, 16'd1234, 16'd1234, 1'b0};
        tbl[2] = '{IDX_IP,   16'd80,   16'd80,   1'b0};
        tbl[3] = '{IDX_WAVE, 16'd999,  16'd999,  1'b0};
`ifdef PULSE_PARAM_CLAMP_EN
        tbl[4] = '{IDX_IP,   16'd120,  16'd80,   1'b1};
        tbl[5] = '{IDX_WAVE, 16'd1001, 16'd1000, 1'b1};
        tbl[6] = '{IDX_IP,   16'd30,   16'd30,   1'b1};
        tbl[7] = '{IDX_TON,  16'hFFFF, 16'hFFFF, 1'b1};
`else
        tbl[4] = '{IDX_IP,   16'd120,  16'd120,  1'b0};
        tbl[5] = '{IDX_WAVE, 16'd1001, 16'd1001, 1'b0};
        tbl[6] = '{IDX_IP,   16'd30,   16'd30,   1'b0};
        tbl[7] = '{IDX_TON,  16'hFFFF, 16'hFFFF, 1'b0};
`endif
        for (int t = 0; t < 8; t++) begin
            pulse_change(tbl[t].slot, tbl[t].val);
            check($sformatf("tbl%0d data", t), 64'(slot_of(param_data, tbl[t].slot)),
                  64'(tbl[t].exp));
            check($sformatf("tbl%0d clamp_err", t), 64'(clamp_err), 64'(tbl[t].exp_err));
            m_data[tbl[t].slot] = tbl[t].exp;
            m_err               = tbl[t].exp_err;
        end
        check_model("post table");

        // Randomized operations against the transaction-level model.
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                rslot = $urandom_range(0, NP - 1);
                if (rslot == IDX_IP)        rv = 16'($urandom_range(0, 150));
                else if (rslot == IDX_WAVE) rv = 16'($urandom_range(0, 2000));
                else                        rv = 16'($urandom());
                pulse_change(rslot, rv);
                model_write(rslot, rv);
            end else if (op <= 6) begin
                pulse_ctl(1'b0);
                if (m_state == 0) m_state = 1;
            end else if (op == 7) begin
                pulse_done();
                if (m_state == 1) model_commit();
            end else begin
                pulse_ctl(1'b1);
                if (m_state == 1) begin
                    m_state = 2;
                    for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                        rslot = $urandom_range(0, NP - 1);
                        rv    = 16'($urandom_range(0, 1500));
                        pulse_change(rslot, rv);
                        model_write(rslot, rv);
                    end
                    if ($urandom_range(0, 1) == 1) pulse_done();
                    else                          repeat (TMO + 20) tick();
                    model_commit();
                    m_state = 0;
                end
            end
            check_model($sformatf("rand%0d op%0d", n, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
